mcd_window_feeder: RTL and testbench

//  Streaming front end for the 3-input median circuit (MCD). Accepts a sample stream

---
 rtl/mcd_window_feeder.sv | 143 ++++++++++++++
 tb/tb_mcd_window_feeder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcd_window_feeder.sv
// mcd_window_feeder: streaming front end for the 3-input median circuit (MCD).
// Keeps a 3-deep sliding window of accepted samples (w0 newest, w2 oldest) that
// drives MCD a/b/c, and returns MCD's median as a valid/ready stream with frame
// tagging. The window registers double as the single output slot.
// Optional feature macro: MCD_EDGE_REPLICATE_EN -- when defined, the first sample
// of a frame is replicated into all three window entries so every accepted
// sample yields a result and short_frame is tied low.
module mcd_window_feeder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] mcd_a,
    output logic [DATA_W-1:0] mcd_b,
    output logic [DATA_W-1:0] mcd_c,
    input  logic [DATA_W-1:0] mcd_median,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              short_frame
);

    // Number of valid entries currently held in the window
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t            state_q, state_d, fill_state;
    logic [DATA_W-1:0] w0_q, w0_d;
    logic [DATA_W-1:0] w1_q, w1_d;
    logic [DATA_W-1:0] w2_q, w2_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              acc;
    logic              xfer;
`ifndef MCD_EDGE_REPLICATE_EN
    logic              short_frame_q, short_frame_d;
`endif

    assign in_ready  = !out_valid_q || out_ready;
    assign acc       = in_valid && in_ready;
    assign xfer      = out_valid_q && out_ready;

    assign mcd_a     = w2_q;
    assign mcd_b     = w1_q;
    assign mcd_c     = w0_q;
    assign out_data  = mcd_median;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

`ifdef MCD_EDGE_REPLICATE_EN
    assign short_frame = 1'b0;
`else
    assign short_frame = short_frame_q;
`endif

    // Next-state: shift the window on accept, advance the fill count, and decide
    // whether the new window is a result, a frame end, or a truncated frame
    always_comb begin
        state_d     = state_q;
        fill_state  = state_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifndef MCD_EDGE_REPLICATE_EN
        short_frame_d = 1'b0;
`endif
        if (acc) begin
            w2_d = w1_q;
            w1_d = w0_q;
            w0_d = in_data;
            case (state_q)
`ifdef MCD_EDGE_REPLICATE_EN
                EMPTY: begin
                    w2_d       = in_data;
                    w1_d       = in_data;
                    fill_state = FULL;
                end
`else
                EMPTY:   fill_state = ONE;
`endif
                ONE:     fill_state = TWO;
                TWO:     fill_state = FULL;
                default: fill_state = FULL;
            endcase

            if (fill_state == FULL) begin
                out_valid_d = 1'b1;
                out_last_d  = in_last;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end

            if (in_last) begin
                state_d = EMPTY;
`ifndef MCD_EDGE_REPLICATE_EN
                short_frame_d = (fill_state != FULL);
`endif
            end else begin
                state_d = fill_state;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // State and window registers; reset discards any pending result at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            w0_q        <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifndef MCD_EDGE_REPLICATE_EN
            short_frame_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifndef MCD_EDGE_REPLICATE_EN
            short_frame_q <= short_frame_d;
`endif
        end
    end

endmodule

// File: tb/tb_mcd_window_feeder.sv
// tb_mcd_window_feeder: scoreboard bench for mcd_window_feeder with a
// behavioural 3-input median standing in for MCD. Honours MCD_EDGE_REPLICATE_EN.
module tb_mcd_window_feeder;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [DATA_W-1:0] mcd_a;
    logic [DATA_W-1:0] mcd_b;
    logic [DATA_W-1:0] mcd_c;
    logic [DATA_W-1:0] mcd_median;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              short_frame;

    int assert_count = 0;
    int fail_count   = 0;
    int out_count    = 0;
    int sf_count     = 0;

    logic [DATA_W:0] exp_q[$];

    // Behavioural MCD: median of three
    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    assign mcd_median = med3(mcd_a, mcd_b, mcd_c);

    mcd_window_feeder #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .mcd_a       (mcd_a),
        .mcd_b       (mcd_b),
        .mcd_c       (mcd_c),
        .mcd_median  (mcd_median),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .short_frame (short_frame)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges beyond every local bound
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    // Drive one sample and hold it until it is accepted at a rising edge
    task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic l);
        int waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) until every expected result has been consumed
    task automatic drain();
        int waits = 0;
        while (exp_q.size() != 0 && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("drain_queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: pop and compare whenever a result is transferred
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [DATA_W:0] e;
            if (exp_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_output actual=%0d required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_data", out_data, e[DATA_W-1:0]);
                checkOutput("out_last", out_last, e[DATA_W]);
            end
            out_count++;
        end
        if (rst_n && short_frame) sf_count++;
    end

    initial begin
        int base;
        int cnt;
        logic [DATA_W-1:0] m0, m1, m2, d;
        logic l;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_short_frame", short_frame, 0);
        checkOutput("rst_mcd_a", mcd_a, 0);
        checkOutput("rst_mcd_b", mcd_b, 0);
        checkOutput("rst_mcd_c", mcd_c, 0);
        rst_n = 1'b1;

        // T1: plain stream
        $display("[TB] T1 plain stream");
`ifdef MCD_EDGE_REPLICATE_EN
        push_exp(32, 0); push_exp(32, 0);
`endif
        push_exp(32, 0); push_exp(16, 0);
        applyStimulus(32, 0);
        applyStimulus(128, 0);
        applyStimulus(4, 0);
        applyStimulus(16, 0);
        go_idle();
        checkOutput("t1_mcd_a", mcd_a, 128);
        checkOutput("t1_mcd_b", mcd_b, 4);
        checkOutput("t1_mcd_c", mcd_c, 16);
        drain();
        do_reset();

        // T2: backpressure holds the result and blocks input
        $display("[TB] T2 backpressure");
        out_ready = 1'b0;
`ifdef MCD_EDGE_REPLICATE_EN
        push_exp(32, 0); push_exp(32, 0);
`endif
        push_exp(32, 0); push_exp(16, 0);
        fork
            begin
                applyStimulus(32, 0);
                applyStimulus(128, 0);
                applyStimulus(4, 0);
                applyStimulus(16, 0);
                go_idle();
            end
            begin
                int waits = 0;
                @(negedge clk);
                while (!out_valid && waits < 50) begin
                    @(negedge clk);
                    waits++;
                end
                checkOutput("t2_out_valid_seen", out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    checkOutput("t2_hold_data", out_data, 32);
                    checkOutput("t2_hold_in_ready", in_ready, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        do_reset();

        // T3: frame end, no mixing into the next frame
        $display("[TB] T3 frame boundary");
`ifdef MCD_EDGE_REPLICATE_EN
        push_exp(10, 0); push_exp(10, 0); push_exp(20, 1);
        push_exp(5, 0); push_exp(5, 0); push_exp(6, 0);
`else
        push_exp(20, 1); push_exp(6, 0);
`endif
        applyStimulus(10, 0);
        applyStimulus(20, 0);
        applyStimulus(30, 1);
        applyStimulus(5, 0);
        applyStimulus(6, 0);
        applyStimulus(7, 0);
        go_idle();
        drain();
        do_reset();

        // T4: short frame
        $display("[TB] T4 short frame");
        sf_count = 0;
        base = out_count;
`ifdef MCD_EDGE_REPLICATE_EN
        push_exp(9, 0); push_exp(9, 1);
`endif
        applyStimulus(9, 0);
        applyStimulus(8, 1);
        go_idle();
        drain();
`ifdef MCD_EDGE_REPLICATE_EN
        checkOutput("t4_out_count", out_count - base, 2);
        checkOutput("t4_short_frame_pulses", sf_count, 0);
`else
        checkOutput("t4_out_count", out_count - base, 0);
        checkOutput("t4_short_frame_pulses", sf_count, 1);
`endif

        // T5: reset mid-frame
        $display("[TB] T5 reset mid-frame");
`ifdef MCD_EDGE_REPLICATE_EN
        push_exp(50, 0); push_exp(50, 0);
`endif
        applyStimulus(50, 0);
        applyStimulus(60, 0);
        go_idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_out_valid", out_valid, 0);
        checkOutput("t5_in_ready", in_ready, 1);
        checkOutput("t5_mcd_a", mcd_a, 0);
        checkOutput("t5_mcd_b", mcd_b, 0);
        checkOutput("t5_mcd_c", mcd_c, 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef MCD_EDGE_REPLICATE_EN
        push_exp(1, 0); push_exp(1, 0);
`endif
        push_exp(2, 1);
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        applyStimulus(3, 1);
        go_idle();
        drain();

        // T6: continuous random stream against a software median model
        $display("[TB] T6 random stream");
        cnt = 0;
        m0 = '0; m1 = '0; m2 = '0;
        for (int i = 0; i < 100; i++) begin
            d = DATA_W'($urandom_range(0, 255));
            l = (i == 99);
`ifdef MCD_EDGE_REPLICATE_EN
            if (cnt == 0) begin
                m0 = d; m1 = d; m2 = d; cnt = 3;
            end else begin
                m2 = m1; m1 = m0; m0 = d;
            end
`else
            m2 = m1; m1 = m0; m0 = d;
            if (cnt < 3) cnt++;
`endif
            if (cnt == 3) push_exp(med3(m2, m1, m0), l);
            if (l) cnt = 0;
            applyStimulus(d, l);
        end
        go_idle();
        drain();

        checkOutput("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
